// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory bus and ir issue bus of the fetch stage
interface instr_fetch_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic [15:0]     imem_data;
  logic            imem_valid;
  logic [0:15]     ir;
  logic            ir_valid;
  logic            ir_ready;
  logic [PC_W-1:0] pc;

  modport master (
    output imem_addr, imem_req, ir, ir_valid, pc,
    input  imem_data, imem_valid, ir_ready
  );

  modport slave (
    input  imem_addr, imem_req, ir, ir_valid, pc,
    output imem_data, imem_valid, ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM, 2-entry {pc, word} queue and run/step issue gate
module instr_fetch #(
  parameter int         PC_W    = 8,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_addr,
  output logic            halt,
  instr_fetch_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] q_pc   [2];
  logic [15:0]     q_word [2];
  logic            head;
  logic [1:0]      count;
  logic            credit;
  logic            step_q;
  logic            discard;

  logic rsp, rsp_halt, push, pop, step_rise, tail;

  // Responses are only taken in WAIT; anything else is stale (post-reset or flushed).
  assign rsp       = (state == WAIT) && bus.imem_valid;
  assign rsp_halt  = rsp && (bus.imem_data[15:12] == HALT_OP);
  assign push      = rsp && !rsp_halt && !redirect;
  assign pop       = bus.ir_valid && bus.ir_ready;
  assign step_rise = step && !step_q;
  assign tail      = head ^ count[0];

  assign bus.ir_valid  = (count != 2'd0) && (run || credit);
  assign bus.ir        = (count != 2'd0) ? q_word[head] : '0;
  assign bus.pc        = (count != 2'd0) ? q_pc[head] : '0;
  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = (state == REQ) ? fetch_pc : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (!redirect && !discard && count != 2'd2) state_next = REQ;
      REQ:    state_next = redirect ? IDLE : WAIT;
      WAIT: begin
        if (redirect)            state_next = IDLE;
        else if (bus.imem_valid) state_next = rsp_halt ? HALTED : IDLE;
      end
      HALTED: if (redirect) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      head     <= 1'b0;
      count    <= 2'd0;
      credit   <= 1'b0;
      step_q   <= 1'b0;
      discard  <= 1'b0;
      halt     <= 1'b0;
    end else begin
      state  <= state_next;
      step_q <= step;

      if (pop) head <= ~head;
      if (redirect) begin
        count <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end

      if (redirect)  fetch_pc <= redirect_addr;
      else if (push) fetch_pc <= fetch_pc + PC_W'(1);

      // A pop and a new step edge together leave the fresh credit in place.
      if (redirect)          credit <= 1'b0;
      else if (step_rise)    credit <= 1'b1;
      else if (pop && !run)  credit <= 1'b0;

      if (redirect && (state == REQ || (state == WAIT && !bus.imem_valid))) discard <= 1'b1;
      else if (bus.imem_valid)                                              discard <= 1'b0;

      if (redirect)      halt <= 1'b0;
      else if (rsp_halt) halt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= fetch_pc;
      q_word[tail] <= bus.imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a variable-latency memory model
module tb_instr_fetch;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic            step = 1'b0;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_addr = '0;
  logic            halt;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .HALT_OP(4'b1111)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .redirect(redirect),
    .redirect_addr(redirect_addr), .halt(halt), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [15:0]     word;
  } exp_t;

  int              n_checks = 0;
  int              n_pass = 0;
  exp_t            sb [$];
  exp_t            mon_e;
  logic [PC_W-1:0] req_log [$];
  int              hs_count = 0;
  int              hs0 = 0;
  int              rl0 = 0;
  int              rl1 = 0;
  bit              seen;

  logic [15:0]     mem [256];
  int              lat = 1;
  bit              mem_pend = 1'b0;
  int              mem_cnt = 0;
  logic [PC_W-1:0] mem_a = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory answers a request seen in cycle c during cycle c+lat.
  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    forever begin
      @(posedge clk); #1;
      bus.imem_valid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          bus.imem_valid = 1'b1;
          bus.imem_data  = mem[mem_a];
          mem_pend       = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (bus.imem_req) begin
        mem_pend = 1'b1;
        mem_cnt  = lat;
        mem_a    = bus.imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req) req_log.push_back(bus.imem_addr);
      if (bus.ir_valid && bus.ir_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check_eq("ir", 32'(bus.ir), 32'(mon_e.word));
          check_eq("pc", 32'(bus.pc), 32'(mon_e.pc));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic exp_push(input logic [PC_W-1:0] p, input logic [15:0] w);
    sb.push_back('{pc: p, word: w});
  endtask

  task automatic mem_fill();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic start_test();
    rst = 1'b1;
    tick(5);
    sb.delete();
    hs0 = hs_count;
    rl0 = req_log.size();
  endtask

  task automatic wait_hs(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && (hs_count - hs0) < n; k++) tick();
    check_eq(tag, 32'(hs_count - hs0), 32'(n));
  endtask

  task automatic wait_req(input logic [PC_W-1:0] addr, input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == addr) found = 1'b1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_req"},      32'(bus.imem_req),  32'd0);
    check_eq({tag, "_addr"},     32'(bus.imem_addr), 32'd0);
    check_eq({tag, "_ir_valid"}, 32'(bus.ir_valid),  32'd0);
    check_eq({tag, "_ir"},       32'(bus.ir),        32'd0);
    check_eq({tag, "_pc"},       32'(bus.pc),        32'd0);
    check_eq({tag, "_halt"},     32'(halt),          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ir_ready = 1'b0;

    // Reset values, first request timing, free-run issue order.
    mem_fill();
    mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h9A7C;
    lat = 1; run = 1'b1; bus.ir_ready = 1'b1;
    start_test();
    @(negedge clk);
    check_zero_outputs("reset");
    exp_push(8'd0, 16'h0123); exp_push(8'd1, 16'h1456); exp_push(8'd2, 16'h9A7C);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_eq("first_req", 32'(bus.imem_req), 32'd1);
    check_eq("first_req_addr", 32'(bus.imem_addr), 32'd0);
    wait_hs("t1_hs", 3, 40);
    tick(10);
    check_eq("t1_nodup", 32'(hs_count - hs0), 32'd3);
    check_eq("t1_halt", 32'(halt), 32'd1);
    check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: queue fills with pc0/pc1 and fetch stops.
    mem_fill();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    bus.ir_ready = 1'b0;
    start_test();
    for (int i = 0; i < 4; i++) exp_push(PC_W'(i), mem[i]);
    rst = 1'b0;
    tick(12);
    check_eq("t2_reqs_held", 32'(req_log.size() - rl0), 32'd2);
    @(negedge clk);
    check_eq("t2_ir_valid", 32'(bus.ir_valid), 32'd1);
    check_eq("t2_head_pc", 32'(bus.pc), 32'd0);
    tick();
    bus.ir_ready = 1'b1;
    wait_hs("t2_hs", 4, 40);
    tick(5);
    if (req_log.size() > rl0 + 2) check_eq("t2_resume_addr", 32'(req_log[rl0 + 2]), 32'd2);
    else check_eq("t2_resume_missing", 32'(req_log.size() - rl0), 32'd3);

    // Single step: one issue per step edge, credit saturates at one.
    mem_fill();
    for (int i = 0; i < 5; i++) mem[i] = 16'h5001 + 16'(i);
    run = 1'b0; bus.ir_ready = 1'b1;
    start_test();
    rst = 1'b0;
    tick(10);
    check_eq("t3_no_credit", 32'(hs_count - hs0), 32'd0);
    for (int i = 0; i < 3; i++) exp_push(PC_W'(i), mem[i]);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0; tick(5);
      check_eq("t3_step_issue", 32'(hs_count - hs0), 32'(i + 1));
    end
    bus.ir_ready = 1'b0;
    exp_push(8'd3, mem[3]);
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0; tick(2);
    bus.ir_ready = 1'b1;
    tick(8);
    check_eq("t3_credit_sat", 32'(hs_count - hs0), 32'd4);

    // HALT at addr 3, then redirect to 0x10.
    mem_fill();
    mem[0] = 16'h6001; mem[1] = 16'h6002; mem[2] = 16'h6003;
    mem[8'h10] = 16'h7010; mem[8'h11] = 16'h7011;
    run = 1'b1; bus.ir_ready = 1'b1; lat = 1;
    start_test();
    for (int i = 0; i < 3; i++) exp_push(PC_W'(i), mem[i]);
    rst = 1'b0;
    wait_hs("t4_hs", 3, 40);
    tick(10);
    check_eq("t4_halt", 32'(halt), 32'd1);
    check_eq("t4_req_count", 32'(req_log.size() - rl0), 32'd4);
    check_eq("t4_last_req", 32'(req_log[req_log.size() - 1]), 32'd3);
    exp_push(8'h10, 16'h7010); exp_push(8'h11, 16'h7011);
    rl1 = req_log.size();
    redirect_addr = 8'h10; redirect = 1'b1; tick(); redirect = 1'b0;
    @(negedge clk);
    check_eq("t4_halt_clr", 32'(halt), 32'd0);
    wait_hs("t4_hs_redir", 5, 40);
    tick(10);
    if (req_log.size() > rl1) check_eq("t4_restart_addr", 32'(req_log[rl1]), 32'h10);
    else check_eq("t4_restart_missing", 32'(req_log.size() - rl1), 32'd1);
    check_eq("t4_rehalt", 32'(halt), 32'd1);

    // Redirect while addr 5 is outstanding (3-cycle latency), then PC wrap.
    mem_fill();
    for (int i = 0; i < 8; i++) mem[i] = 16'h8000 + 16'(i);
    mem[8'h40] = 16'h8440; mem[8'h41] = 16'h8441;
    lat = 3;
    start_test();
    for (int i = 0; i < 5; i++) exp_push(PC_W'(i), mem[i]);
    rst = 1'b0;
    wait_req(8'd5, 100, seen);
    check_eq("t5_req5_seen", 32'(seen), 32'd1);
    tick();
    exp_push(8'h40, 16'h8440); exp_push(8'h41, 16'h8441);
    redirect_addr = 8'h40; redirect = 1'b1; tick(); redirect = 1'b0;
    wait_hs("t5_hs", 7, 80);
    tick(15);
    check_eq("t5_halt", 32'(halt), 32'd1);
    check_eq("t5_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("t5_req_before", 32'(req_log[req_log.size() - 4]), 32'd5);
    check_eq("t5_req_after", 32'(req_log[req_log.size() - 3]), 32'h40);
    mem[8'hFE] = 16'h9FE0; mem[8'hFF] = 16'h9FF0; mem[0] = 16'h9000; mem[1] = 16'hF000;
    lat = 1;
    exp_push(8'hFE, 16'h9FE0); exp_push(8'hFF, 16'h9FF0); exp_push(8'h00, 16'h9000);
    redirect_addr = 8'hFE; redirect = 1'b1; tick(); redirect = 1'b0;
    wait_hs("t5_wrap_hs", 10, 60);
    tick(5);
    check_eq("t5_wrap_halt", 32'(halt), 32'd1);

    // Reset during WAIT; the late response must be ignored.
    mem_fill();
    mem[0] = 16'hA000; mem[1] = 16'hA001;
    lat = 3;
    start_test();
    exp_push(8'd0, 16'hA000); exp_push(8'd1, 16'hA001);
    rst = 1'b0;
    wait_req(8'd0, 20, seen);
    check_eq("t6_req0_seen", 32'(seen), 32'd1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("t6_rst");
    wait_hs("t6_hs", 2, 60);
    tick(15);
    check_eq("t6_nodup", 32'(hs_count - hs0), 32'd2);
    check_eq("t6_halt", 32'(halt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and issue stage: the producer side of the 16-bit `ir` instruction bus that the ALU stage decodes. It walks a program counter through instruction memory and buffers fetched words in a 2-entry queue. It presents each instruction with a valid/ready handshake, either free-running or one per step pulse. It also handles a PC redirect and a HALT opcode.

## Interface
- `PC_W`, 8, program-counter / instruction-memory address width
- `HALT_OP`, 4'b1111, opcode in `ir[0:3]` that stops fetching
- `clk`  in  1  system clock; everything is on its rising edge
- `rst`  in  1  reset, synchronous and active-high
- `run`  in  1  1 = free-run issue; 0 = single-step issue
- `step`  in  1  single-step request; a rising edge (sampled on `clk`) grants one issue credit
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_addr`
- `redirect_addr`  in  PC_W  new PC when `redirect`=1
- `imem_addr`  out  PC_W  fetch address, valid while `imem_req`=1
- `imem_req`  out  1  one-cycle fetch request pulse
- `imem_data`  in  16  fetched word, valid with `imem_valid`
- `imem_valid`  in  1  response strobe, at least 1 cycle after `imem_req`
- `ir`  out  [0:15]  instruction presented to execute; opcode in `ir[0:3]`
- `ir_valid`  out  1  `ir`/`pc` valid
- `ir_ready`  in  1  execute stage accepts `ir` this cycle
- `pc`  out  PC_W  address of the word in `ir`
- `halt`  out  1  a HALT word was fetched; fetching stopped

## Operation
- Queue: 2 entries of {pc, word}. `ir`/`pc` show the head entry and are 0 when the queue is empty.
- Issue gate:
  - `ir_valid` = queue non-empty AND (`run` OR `credit`).
  - Handshake completes when `ir_valid` AND `ir_ready`; this pops the head.
  - `credit` is a 1-bit register, set on a `step` rising edge and cleared by a completed handshake with `run`=0. Multiple step edges before a handshake saturate at one credit.
- Only one memory request is outstanding at a time.
- Fetch FSM states:
  - IDLE → REQ when (queue count + outstanding) < 2 and not halted.
  - REQ: pulses `imem_req` with `imem_addr`=fetch PC, then → WAIT.
  - WAIT: on `imem_valid`, → IDLE.
  - HALTED: entered after a HALT word returns.
- Response handling:
  - A normal word is enqueued with its address, and the fetch PC increments.
  - A word with `ir[0:3]`==HALT_OP is not enqueued. `halt` sets the next cycle and the FSM goes to HALTED. Entries already queued still drain.
- PC arithmetic is modulo 2^PC_W: 2^PC_W−1 wraps to 0.
- Redirect:
  - Empties the queue and clears `credit` and `halt`.
  - Sets fetch PC = `redirect_addr` and returns the FSM to IDLE.
  - If a request is outstanding, its response is dropped through a discard flag, and no new request issues until that response arrives.
- Simultaneous events:
  - Redirect with handshake: the handshake completes (the consumer keeps that word), then the flush happens.
  - Redirect with `imem_valid`: the response is discarded.
  - Enqueue and pop in the same cycle: count is unchanged.
- HALTED exits only on `redirect` or `rst`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `ir`=0, `ir_valid`=0, `pc`=0, `halt`=0, `credit`=0, queue empty, fetch PC=0, FSM IDLE.
- First `imem_req` (addr 0) is in the first cycle after `rst` deasserts.
- A word is enqueued in its `imem_valid` cycle and `ir_valid` rises the next cycle. Minimum req→`ir_valid` is 2 cycles.
- `rst` during an outstanding request: state is cleared, and a late `imem_valid` arriving in the first cycle after reset is ignored.
- `halt` rises 1 cycle after the HALT word's `imem_valid`.
- Step edge at cycle t: `credit`=1 and `ir_valid` can assert at t+1 if the queue is non-empty.

## Test plan
- Free-run, memory with 1-cycle latency holding 0x0123, 0x1456, 0x9A7C, `ir_ready`=1 → `ir` sequence 0x0123/pc0, 0x1456/pc1, 0x9A7C/pc2, no duplicates and no gaps.
- `ir_ready`=0 for 10 cycles → queue holds pc0, pc1; `imem_req` stays idle; release → both issue in order, then fetch resumes at pc2.
- Single-step, queue full, three step pulses 5 cycles apart → exactly three handshakes, one per pulse. Two step edges without a handshake in between → only one issue.
- HALT at addr 3 (0xF000) → words 0–2 issue, `halt`=1, no `imem_req` after addr 3. Then `redirect` to 0x10 → `halt`=0 and fetching restarts at 0x10.
- `redirect` to 0x40 while a request to addr 5 is outstanding (3-cycle latency) → addr 5 data dropped, first issued `ir` is from 0x40. PC starting at 0xFE → addresses 0xFE, 0xFF, 0x00.
- `rst` asserted mid-WAIT → all outputs 0 next cycle; fetch restarts at addr 0.
